// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer: arbitrates trap, sc, rfi and external requests,
// flushes and drains the pipeline, saves SRR0/SRR1 and redirects fetch to the vector.
module int_sequencer #(
    parameter int          PC_WIDTH  = 32,
    parameter int          MSR_WIDTH = 32,
    parameter int          EE_BIT    = 16,
    parameter logic [15:0] IVPR_BASE = 16'h0000,
    parameter logic [3:0]  IVOR_EXT  = 4'd4,
    parameter logic [3:0]  IVOR_TRAP = 4'd6,
    parameter logic [3:0]  IVOR_SC   = 4'd8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trap_req,
    input  logic                 sc_req,
    input  logic                 hw_int,
    input  logic                 rfi_req,
    input  logic [PC_WIDTH-1:0]  exc_pc,
    input  logic [PC_WIDTH-1:0]  resume_pc,
    input  logic [MSR_WIDTH-1:0] msr_in,
    input  logic                 drain_done,
    output logic                 flush,
    output logic                 stall,
    output logic                 msr_we,
    output logic [MSR_WIDTH-1:0] msr_wdata,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [PC_WIDTH-1:0]  srr0,
    output logic [MSR_WIDTH-1:0] srr1,
    output logic                 int_ack,
    output logic [3:0]           cause
);

    // MSR bits use big-endian numbering, so EE sits at MSR_WIDTH-1-EE_BIT in vector terms.
    localparam int EE_POS = MSR_WIDTH - 1 - EE_BIT;
    localparam logic [MSR_WIDTH-1:0] EE_MASK = {{(MSR_WIDTH-1){1'b0}}, 1'b1} << EE_POS;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        DRAIN,
        SAVE,
        VECTOR,
        RFI
    } state_t;

    state_t                 state_q;
    logic                   ext_pend_q;
    logic                   ext_pend_d;
    logic [PC_WIDTH-1:0]    save_pc_q;
    logic [3:0]             cause_q;
    logic [PC_WIDTH-1:0]    srr0_q;
    logic [MSR_WIDTH-1:0]   srr1_q;
    logic [MSR_WIDTH-1:0]   msr_wdata_q;
    logic [PC_WIDTH-1:0]    redirect_pc_q;
    logic                   flush_q;
    logic                   stall_q;
    logic                   msr_we_q;
    logic                   redirect_valid_q;
    logic                   int_ack_q;
    logic [PC_WIDTH-1:0]    vector_pc;

    assign vector_pc = PC_WIDTH'({IVPR_BASE, 8'h00, cause_q, 4'h0});

    // The clear from taking the external interrupt beats a re-arm in the same cycle.
    always_comb begin
        ext_pend_d = ext_pend_q;
        if (state_q == SAVE && cause_q == IVOR_EXT) begin
            ext_pend_d = 1'b0;
        end else if (hw_int && msr_in[EE_POS]) begin
            ext_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            ext_pend_q       <= 1'b0;
            save_pc_q        <= '0;
            cause_q          <= '0;
            srr0_q           <= '0;
            srr1_q           <= '0;
            msr_wdata_q      <= '0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            msr_we_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            int_ack_q        <= 1'b0;
        end else begin
            ext_pend_q       <= ext_pend_d;
            flush_q          <= 1'b0;
            msr_we_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            int_ack_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trap_req) begin
                        cause_q   <= IVOR_TRAP;
                        save_pc_q <= exc_pc;
                        state_q   <= FLUSH;
                        flush_q   <= 1'b1;
                        stall_q   <= 1'b1;
                    end else if (sc_req) begin
                        cause_q   <= IVOR_SC;
                        save_pc_q <= exc_pc + PC_WIDTH'(4);
                        state_q   <= FLUSH;
                        flush_q   <= 1'b1;
                        stall_q   <= 1'b1;
                    end else if (rfi_req) begin
                        // rfi is the oldest instruction, so no drain is needed.
                        state_q          <= RFI;
                        flush_q          <= 1'b1;
                        stall_q          <= 1'b1;
                        msr_we_q         <= 1'b1;
                        msr_wdata_q      <= srr1_q;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= srr0_q;
                    end else if (ext_pend_q) begin
                        cause_q   <= IVOR_EXT;
                        save_pc_q <= resume_pc;
                        state_q   <= FLUSH;
                        flush_q   <= 1'b1;
                        stall_q   <= 1'b1;
                    end
                end
                FLUSH: begin
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q     <= SAVE;
                        int_ack_q   <= 1'b1;
                        msr_we_q    <= 1'b1;
                        msr_wdata_q <= msr_in & ~EE_MASK;
                    end
                end
                SAVE: begin
                    srr0_q           <= save_pc_q;
                    srr1_q           <= msr_in;
                    state_q          <= VECTOR;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= vector_pc;
                end
                VECTOR: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
                RFI: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush          = flush_q;
    assign stall          = stall_q;
    assign msr_we         = msr_we_q;
    assign msr_wdata      = msr_wdata_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign srr0           = srr0_q;
    assign srr1           = srr1_q;
    assign int_ack        = int_ack_q;
    assign cause          = cause_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios followed by random
// interrupt/rfi transactions checked against a transaction-level model.
module tb_int_sequencer;

    localparam logic [31:0] EE_MASK   = 32'h0000_8000;
    localparam int          IVPR_BASE = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_req;
    logic        sc_req;
    logic        hw_int;
    logic        rfi_req;
    logic [31:0] exc_pc;
    logic [31:0] resume_pc;
    logic [31:0] msr_in;
    logic        drain_done;
    logic        flush;
    logic        stall;
    logic        msr_we;
    logic [31:0] msr_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] srr0;
    logic [31:0] srr1;
    logic        int_ack;
    logic [3:0]  cause;

    int checks = 0;
    int failures = 0;
    logic [31:0] srr0Model;
    logic [31:0] srr1Model;

    int_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .trap_req       (trap_req),
        .sc_req         (sc_req),
        .hw_int         (hw_int),
        .rfi_req        (rfi_req),
        .exc_pc         (exc_pc),
        .resume_pc      (resume_pc),
        .msr_in         (msr_in),
        .drain_done     (drain_done),
        .flush          (flush),
        .stall          (stall),
        .msr_we         (msr_we),
        .msr_wdata      (msr_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .srr0           (srr0),
        .srr1           (srr1),
        .int_ack        (int_ack),
        .cause          (cause)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] vectorOf(input int ivor);
        return 32'(IVPR_BASE * 65536 + ivor * 16);
    endfunction

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Control bits packed as {flush, stall, msr_we, redirect_valid, int_ack}.
    task automatic checkControl(input string tag, input logic [4:0] expected);
        checkOutput(tag, 32'({flush, stall, msr_we, redirect_valid, int_ack}), 32'(expected));
    endtask

    // Called while observing IDLE with the request already driven; returns observing IDLE.
    task automatic runInterrupt(input string tag, input int drainWait, input logic [31:0] expSrr0,
                                input logic [31:0] expSrr1, input int expCause);
        applyStimulus();
        checkControl({tag, "/flush"}, 5'b11000);
        trap_req = 1'b0;
        sc_req   = 1'b0;
        for (int i = 0; i <= drainWait; i++) begin
            applyStimulus();
            checkControl({tag, "/drain"}, 5'b01000);
            drain_done = (i == drainWait);
        end
        applyStimulus();
        drain_done = 1'b0;
        checkControl({tag, "/save"}, 5'b01101);
        checkOutput({tag, "/msr_wdata"}, msr_wdata, expSrr1 & ~EE_MASK);
        applyStimulus();
        checkControl({tag, "/vector"}, 5'b01010);
        checkOutput({tag, "/redirect_pc"}, redirect_pc, vectorOf(expCause));
        checkOutput({tag, "/srr0"}, srr0, expSrr0);
        checkOutput({tag, "/srr1"}, srr1, expSrr1);
        checkOutput({tag, "/cause"}, 32'(cause), 32'(expCause));
        // The core's MSR register takes the write issued during SAVE.
        msr_in = expSrr1 & ~EE_MASK;
        applyStimulus();
        checkControl({tag, "/idle"}, 5'b00000);
        srr0Model = expSrr0;
        srr1Model = expSrr1;
    endtask

    task automatic runRfi(input string tag);
        rfi_req = 1'b1;
        applyStimulus();
        checkControl({tag, "/rfi"}, 5'b11110);
        checkOutput({tag, "/msr_wdata"}, msr_wdata, srr1Model);
        checkOutput({tag, "/redirect_pc"}, redirect_pc, srr0Model);
        rfi_req = 1'b0;
        msr_in  = srr1Model;
        applyStimulus();
        checkControl({tag, "/idle"}, 5'b00000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] msr;
        int kind;
        int wait_cycles;

        rst = 1'b1;
        trap_req = 1'b0;
        sc_req = 1'b0;
        hw_int = 1'b0;
        rfi_req = 1'b0;
        exc_pc = '0;
        resume_pc = '0;
        msr_in = '0;
        drain_done = 1'b0;
        srr0Model = '0;
        srr1Model = '0;
        applyStimulus();
        applyStimulus();
        checkControl("reset/ctrl", 5'b00000);
        checkOutput("reset/srr0", srr0, 32'h0);
        checkOutput("reset/redirect_pc", redirect_pc, 32'h0);
        rst = 1'b0;
        applyStimulus();

        $display("[TB] trap entry");
        exc_pc   = 32'h0000_1000;
        msr_in   = 32'h0000_8000;
        trap_req = 1'b1;
        runInterrupt("trap", 2, 32'h0000_1000, 32'h0000_8000, 6);

        $display("[TB] simultaneous trap, sc and external");
        msr_in    = 32'h0000_8000;
        exc_pc    = 32'h0000_0500;
        resume_pc = 32'h0000_0A00;
        trap_req  = 1'b1;
        sc_req    = 1'b1;
        hw_int    = 1'b1;
        runInterrupt("prio_trap", 0, 32'h0000_0500, 32'h0000_8000, 6);
        runInterrupt("prio_ext", 1, 32'h0000_0A00, 32'h0000_0000, 4);
        hw_int = 1'b0;

        $display("[TB] external masked by EE");
        msr_in    = 32'h0000_0000;
        hw_int    = 1'b1;
        resume_pc = 32'h0000_0C40;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkControl("masked", 5'b00000);
        end
        msr_in = 32'h0000_8000;
        applyStimulus();
        checkControl("unmask", 5'b00000);
        runInterrupt("ext", 0, 32'h0000_0C40, 32'h0000_8000, 4);
        hw_int = 1'b0;

        $display("[TB] sc with wrap");
        exc_pc = 32'hFFFF_FFFC;
        msr_in = 32'h0000_8000;
        sc_req = 1'b1;
        runInterrupt("sc_wrap", 1, 32'h0000_0000, 32'h0000_8000, 8);

        $display("[TB] rfi");
        exc_pc = 32'h0000_2000;
        msr_in = 32'h0000_8000;
        sc_req = 1'b1;
        runInterrupt("sc", 0, 32'h0000_2004, 32'h0000_8000, 8);
        runRfi("rfi");

        $display("[TB] reset mid-sequence");
        exc_pc   = 32'h0000_3000;
        trap_req = 1'b1;
        applyStimulus();
        trap_req = 1'b0;
        applyStimulus();
        checkControl("pre_reset/drain", 5'b01000);
        rst = 1'b1;
        #1;
        checkControl("midreset/ctrl", 5'b00000);
        checkOutput("midreset/srr0", srr0, 32'h0);
        checkOutput("midreset/srr1", srr1, 32'h0);
        checkOutput("midreset/cause", 32'(cause), 32'h0);
        checkOutput("midreset/msr_wdata", msr_wdata, 32'h0);
        applyStimulus();
        rst = 1'b0;
        srr0Model = '0;
        srr1Model = '0;
        applyStimulus();
        checkControl("postreset/idle", 5'b00000);

        $display("[TB] random transactions");
        for (int n = 0; n < 40; n++) begin
            kind        = int'($urandom_range(0, 4));
            wait_cycles = int'($urandom_range(0, 3));
            pc          = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFFC;
            msr         = $urandom;
            case (kind)
                0: begin
                    exc_pc = pc;
                    msr_in = msr;
                    trap_req = 1'b1;
                    runInterrupt("rnd_trap", wait_cycles, pc, msr, 6);
                end
                1: begin
                    exc_pc = pc;
                    msr_in = msr;
                    sc_req = 1'b1;
                    runInterrupt("rnd_sc", wait_cycles, pc + 32'd4, msr, 8);
                end
                2: begin
                    resume_pc = pc;
                    msr_in = msr | EE_MASK;
                    hw_int = 1'b1;
                    applyStimulus();
                    hw_int = 1'b0;
                    runInterrupt("rnd_ext", wait_cycles, pc, msr | EE_MASK, 4);
                end
                3: begin
                    runRfi("rnd_rfi");
                end
                default: begin
                    exc_pc = pc;
                    resume_pc = ~pc;
                    msr_in = msr | EE_MASK;
                    trap_req = 1'b1;
                    hw_int = 1'b1;
                    runInterrupt("rnd_combo_trap", wait_cycles, pc, msr | EE_MASK, 6);
                    runInterrupt("rnd_combo_ext", 0, ~pc, msr & ~EE_MASK, 4);
                    hw_int = 1'b0;
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Sequences interrupt entry and return for the PPC core.
- Arbitrates trap, system-call and external requests, then flushes and drains the pipeline.
- Saves SRR0/SRR1, clears MSR[EE] and redirects fetch to the vector address.
- Handles rfi by restoring MSR from SRR1 and redirecting fetch to SRR0.
- Sits between decode/EX exception detection, the MSR register and the PC-select mux.

Parameters:
PC_WIDTH, 32, width of PC, SRR0 and redirect address
MSR_WIDTH, 32, width of MSR and SRR1
EE_BIT, 16, index of EE in MSR ([0:MSR_WIDTH-1] big-endian numbering)
IVPR_BASE, 16'h0000, upper 16 bits of every vector address
IVOR_EXT, 4'd4, vector index for external interrupt
IVOR_TRAP, 4'd6, vector index for trap
IVOR_SC, 4'd8, vector index for system call

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
trap_req  in  1  trap condition true for the instruction in EX (tw/twi), level
sc_req  in  1  sc instruction in EX, level
hw_int  in  1  external interrupt line, level
rfi_req  in  1  rfi instruction in EX, level
exc_pc  in  PC_WIDTH  PC of the instruction in EX
resume_pc  in  PC_WIDTH  PC of the oldest uncompleted instruction (external case)
msr_in  in  MSR_WIDTH  current MSR value
drain_done  in  1  pipeline empty after flush
flush  out  1  one-cycle pulse that kills all in-flight instructions
stall  out  1  freeze fetch/decode while sequencing
msr_we  out  1  MSR write strobe, one cycle
msr_wdata  out  MSR_WIDTH  MSR write data
redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
redirect_pc  out  PC_WIDTH  new fetch address
srr0  out  PC_WIDTH  save/restore register 0
srr1  out  MSR_WIDTH  save/restore register 1
int_ack  out  1  one-cycle pulse when an interrupt is taken
cause  out  4  IVOR index of the last taken interrupt

Behaviour:
- Reset (asynchronous, any state, mid-sequence included): state=IDLE, ext_pend=0.
  - All outputs 0: srr0, srr1, cause, redirect_pc, msr_wdata.
- ext_pend: set when hw_int & msr_in[EE_BIT]; cleared in SAVE when the taken cause is external. Set has priority over clear only if hw_int is still high after SAVE (the clear wins in that cycle, and the flag re-arms next cycle).
- Priority, evaluated only in IDLE: trap > sc > rfi > ext_pend. Requests raised in any other state are ignored; flushed instructions re-present after redirect.
- States:
  - IDLE, stall=0. On trap/sc/ext_pend, capture cause and SRR0 candidate, then go to FLUSH.
    - trap: SRR0 = exc_pc.
    - sc: SRR0 = exc_pc+4, wrapping mod 2^PC_WIDTH.
    - ext: SRR0 = resume_pc.
    - On rfi_req go to RFI.
  - FLUSH: flush=1 and stall=1 for exactly one cycle, then go to DRAIN.
  - DRAIN: stall=1; remain until drain_done=1, then go to SAVE. No timeout.
  - SAVE: stall=1, int_ack=1, srr0<=captured PC, srr1<=msr_in, msr_we=1, msr_wdata=msr_in with bit EE_BIT cleared; go to VECTOR.
  - VECTOR: stall=1, redirect_valid=1, redirect_pc={IVPR_BASE, 8'h00, cause, 4'h0}; go to IDLE.
  - RFI: flush=1, stall=1, msr_we=1, msr_wdata=srr1, redirect_valid=1, redirect_pc=srr0; go to IDLE. Total 1 cycle; no drain, because rfi is the oldest instruction.
- Latency: request in IDLE at cycle T gives flush at T+1, SAVE at the first cycle after drain_done, and redirect the cycle after SAVE.
- Minimum trap-to-redirect time is 4 cycles, reached when drain_done is already high in DRAIN.
- An external interrupt pending during RFI is taken on the next IDLE evaluation if the restored EE=1; the ext_pend flag is retained.
- Outputs flush, msr_we, redirect_valid and int_ack are single-cycle pulses; all outputs are registered or decoded from state only.

Test Plan:
- Reset mid-sequence: assert rst during DRAIN -> state IDLE, stall=0, srr0=0, and all pulse outputs 0 in the same cycle.
- Trap: trap_req=1, exc_pc=32'h0000_1000, msr_in=32'h0000_8000, drain_done=1 after 2 cycles.
  - flush pulses once.
  - srr0=32'h0000_1000, srr1=32'h0000_8000, msr_wdata=32'h0.
  - redirect_pc=32'h0000_0060, cause=6.
- sc with wrap: sc_req=1, exc_pc=32'hFFFF_FFFC -> srr0=32'h0000_0000, redirect_pc=32'h0000_0080.
- Simultaneous trap_req, sc_req and hw_int with EE=1 -> trap taken first (cause=6).
  - After the return to IDLE, ext_pend is still set, so external is taken next with redirect_pc=32'h0000_0040.
- hw_int=1 with msr_in[EE]=0 for 10 cycles -> no flush and ext_pend stays 0. When EE goes to 1, ext is taken with srr0=resume_pc.
- rfi: srr0=32'h0000_2004, srr1=32'h0000_8000, rfi_req=1 -> next cycle msr_we=1, msr_wdata=32'h0000_8000, redirect_pc=32'h0000_2004, flush=1, back in IDLE one cycle later.
